// File: rtl/result_uart_sender.sv
// Streams the result BRAM to the host UART: a header byte, then each word as
// big-endian sign-extended bytes, then an XOR checksum of the data bytes.
module result_uart_sender #(
  parameter int         DATA_WIDTH     = 17,
  parameter int         BYTES_PER_WORD = 3,
  parameter int         NUM_WORDS      = 192,
  parameter int         ADDR_WIDTH     = 8,
  parameter int         READ_LATENCY   = 1,
  parameter logic [7:0] HEADER_BYTE    = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  busy,
  output logic                  done
);
  localparam int SW = 8 * BYTES_PER_WORD;
  localparam int BW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [BW-1:0]         LAST_BYTE = BW'(BYTES_PER_WORD - 1);
  localparam logic [1:0]            LAT_LOAD  = 2'(READ_LATENCY - 1);
  localparam logic [1:0]            ACK_LOAD  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_FETCH, S_RDWAIT, S_LOAD,
    S_SEND, S_ACKH, S_ACKL, S_NEXT, S_FIN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [BW-1:0]         byte_idx_q, byte_idx_d;
  logic [SW-1:0]         sreg_q, sreg_d;
  logic [7:0]            csum_q, csum_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [1:0]            tmr_q, tmr_d;
  logic                  is_hdr_q, is_hdr_d;
  logic                  is_csum_q, is_csum_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      rd_addr_q  <= '0;
      byte_idx_q <= '0;
      sreg_q     <= '0;
      csum_q     <= '0;
      tx_data_q  <= '0;
      tmr_q      <= '0;
      is_hdr_q   <= 1'b0;
      is_csum_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      rd_addr_q  <= rd_addr_d;
      byte_idx_q <= byte_idx_d;
      sreg_q     <= sreg_d;
      csum_q     <= csum_d;
      tx_data_q  <= tx_data_d;
      tmr_q      <= tmr_d;
      is_hdr_q   <= is_hdr_d;
      is_csum_q  <= is_csum_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    rd_addr_d  = rd_addr_q;
    byte_idx_d = byte_idx_q;
    sreg_d     = sreg_q;
    csum_d     = csum_q;
    tx_data_d  = tx_data_q;
    tmr_d      = tmr_q;
    is_hdr_d   = is_hdr_q;
    is_csum_d  = is_csum_q;
    rd_en      = 1'b0;
    tx_start   = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          csum_d     = '0;
          word_cnt_d = '0;
          is_csum_d  = 1'b0;
          state_d    = S_HDR;
        end
      end
      S_HDR: begin
        tx_data_d = HEADER_BYTE;
        is_hdr_d  = 1'b1;
        state_d   = S_SEND;
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        tmr_d   = LAT_LOAD;
        state_d = S_RDWAIT;
      end
      S_RDWAIT: begin
        if (tmr_q == 2'd0) begin
          sreg_d     = SW'($signed(rd_data));
          byte_idx_d = '0;
          state_d    = S_LOAD;
        end else begin
          tmr_d = tmr_q - 2'd1;
        end
      end
      S_LOAD: begin
        tx_data_d = sreg_q[SW-1 -: 8];
        csum_d    = csum_q ^ sreg_q[SW-1 -: 8];
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          tmr_d    = ACK_LOAD;
          state_d  = S_ACKH;
        end
      end
      // Timeout covers a UART that never shows busy for this byte.
      S_ACKH: begin
        if (tx_busy || tmr_q == 2'd0) state_d = S_ACKL;
        else                          tmr_d   = tmr_q - 2'd1;
      end
      S_ACKL: begin
        if (!tx_busy) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (is_hdr_q) begin
          is_hdr_d = 1'b0;
          state_d  = S_FETCH;
        end else if (is_csum_q) begin
          state_d = S_FIN;
        end else if (byte_idx_q != LAST_BYTE) begin
          sreg_d     = sreg_q << 8;
          byte_idx_d = byte_idx_q + 1'b1;
          state_d    = S_LOAD;
        end else if (word_cnt_q == LAST_WORD) begin
          tx_data_d = csum_q;
          is_csum_d = 1'b1;
          state_d   = S_SEND;
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Address moves only on the edge that opens a read, so it holds otherwise.
    if (state_d == S_FETCH) rd_addr_d = word_cnt_d;
  end

  assign rd_addr = rd_addr_q;
  assign tx_data = tx_data_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_result_uart_sender.sv
// Bench for result_uart_sender: a 2-word frame at read latency 2 and a full
// 192-word frame at latency 1, each scored byte-by-byte against a queue.
module tb_result_uart_sender;
  localparam int DW = 17;
  localparam int AW = 8;
  localparam int NS = 2;
  localparam int NF = 192;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  logic          start_s = 1'b0, hold_s = 1'b0;
  logic          rd_en_s, tx_start_s, tx_busy_s, busy_s, done_s;
  logic [AW-1:0] rd_addr_s;
  logic [DW-1:0] rd_data_s;
  logic [7:0]    tx_data_s;
  logic          start_f = 1'b0, hold_f = 1'b0;
  logic          rd_en_f, tx_start_f, tx_busy_f, busy_f, done_f;
  logic [AW-1:0] rd_addr_f;
  logic [DW-1:0] rd_data_f;
  logic [7:0]    tx_data_f;

  result_uart_sender #(.NUM_WORDS(NS), .READ_LATENCY(2)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .rd_en(rd_en_s), .rd_addr(rd_addr_s),
    .rd_data(rd_data_s), .tx_data(tx_data_s), .tx_start(tx_start_s), .tx_busy(tx_busy_s),
    .busy(busy_s), .done(done_s));

  result_uart_sender #(.NUM_WORDS(NF), .READ_LATENCY(1)) dut_f (
    .clk(clk), .reset(reset), .start(start_f), .rd_en(rd_en_f), .rd_addr(rd_addr_f),
    .rd_data(rd_data_f), .tx_data(tx_data_f), .tx_start(tx_start_f), .tx_busy(tx_busy_f),
    .busy(busy_f), .done(done_f));

  // BRAM models: 2-cycle pipeline for the small frame, 1-cycle for the full one.
  logic [DW-1:0] mem_s [NS];
  logic [DW-1:0] mem_f [NF];
  logic [DW-1:0] p1_s = '0, p2_s = '0, p_f = '0;
  always @(posedge clk) begin
    if (rd_en_s) p1_s <= mem_s[rd_addr_s[0]];
    p2_s <= p1_s;
    if (rd_en_f) p_f <= (int'(rd_addr_f) < NF) ? mem_f[rd_addr_f] : '0;
  end
  assign rd_data_s = p2_s;
  assign rd_data_f = p_f;

  // UART models: busy for 10 cycles starting the cycle after each tx_start.
  int nbytes_s = 0, useen_s = 0, ucnt_s = 0;
  int nbytes_f = 0, useen_f = 0, ucnt_f = 0;
  always @(posedge clk) begin
    if (nbytes_s != useen_s) begin useen_s <= nbytes_s; ucnt_s <= 10; end
    else if (ucnt_s != 0) ucnt_s <= ucnt_s - 1;
    if (nbytes_f != useen_f) begin useen_f <= nbytes_f; ucnt_f <= 10; end
    else if (ucnt_f != 0) ucnt_f <= ucnt_f - 1;
  end
  assign tx_busy_s = (ucnt_s != 0) || hold_s;
  assign tx_busy_f = (ucnt_f != 0) || hold_f;

  logic [7:0]  q_s [$];
  logic [7:0]  q_f [$];
  logic [31:0] exp_s, exp_f;
  logic [31:0] last4_f = '0;
  int fbytes_s = 0, raddr_s = 0, ndone_s = 0, hdr_cyc_s = 0;
  int fbytes_f = 0, raddr_f = 0, ndone_f = 0;
  logic prev_start_s = 1'b0, prev_busy_s = 1'b0;
  logic prev_start_f = 1'b0, prev_busy_f = 1'b0;

  always @(negedge clk) begin
    if (busy_s && !prev_busy_s) begin fbytes_s = 0; raddr_s = 0; end
    if (tx_start_s) begin
      chk("s_start_vs_busy", tx_busy_s, 0);
      chk("s_start_b2b", prev_start_s, 0);
      if (q_s.size() != 0) exp_s = {24'h0, q_s.pop_front()};
      else                 exp_s = 32'h1FF;
      chk("s_tx_byte", tx_data_s, exp_s);
      if (fbytes_s == 0) hdr_cyc_s = cyc;
      fbytes_s++;
      nbytes_s++;
    end
    if (rd_en_s) begin
      chk("s_rd_addr", rd_addr_s, raddr_s);
      raddr_s++;
    end
    if (done_s) ndone_s++;
    prev_start_s = tx_start_s;
    prev_busy_s  = busy_s;
  end

  always @(negedge clk) begin
    if (busy_f && !prev_busy_f) begin fbytes_f = 0; raddr_f = 0; end
    if (tx_start_f) begin
      chk("f_start_vs_busy", tx_busy_f, 0);
      chk("f_start_b2b", prev_start_f, 0);
      if (q_f.size() != 0) exp_f = {24'h0, q_f.pop_front()};
      else                 exp_f = 32'h1FF;
      chk("f_tx_byte", tx_data_f, exp_f);
      last4_f = {last4_f[23:0], tx_data_f};
      fbytes_f++;
      nbytes_f++;
    end
    if (rd_en_f) begin
      chk("f_rd_addr", rd_addr_f, raddr_f);
      raddr_f++;
    end
    if (done_f) ndone_f++;
    prev_start_f = tx_start_f;
    prev_busy_f  = busy_f;
  end

  task automatic pulse(input bit use_f);
    @(posedge clk); #1;
    if (use_f) start_f = 1'b1; else start_s = 1'b1;
    @(posedge clk); #1;
    start_f = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic wait_done(input bit use_f, input int budget, input bit start_at_fin,
                           input string tag);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if ((use_f ? done_f : done_s) == 1'b1) begin
        got = 1'b1;
        if (start_at_fin) begin
          start_s = 1'b1;
          @(posedge clk); #1;
          start_s = 1'b0;
        end
        break;
      end
    end
    chk(tag, {31'h0, got}, 1);
  endtask

  task automatic push_frame_s();
    logic [7:0] fr [8];
    fr = '{8'hA5, 8'hFF, 8'h02, 8'h03, 8'h00, 8'h00, 8'hA5, 8'h5B};
    foreach (fr[i]) q_s.push_back(fr[i]);
  endtask

  task automatic push_frame_f(output logic [7:0] csum);
    logic [23:0] w;
    csum = 8'h00;
    q_f.push_back(8'hA5);
    for (int i = 0; i < NF; i++) begin
      w = {{7{mem_f[i][DW-1]}}, mem_f[i]};
      for (int b = 2; b >= 0; b--) begin
        q_f.push_back(w[8*b +: 8]);
        csum = csum ^ w[8*b +: 8];
      end
    end
    q_f.push_back(csum);
  endtask

  task automatic frame_checks_s(input int d0, input string tag);
    repeat (40) @(posedge clk);
    #1;
    chk({tag, "_done_cnt"}, ndone_s - d0, 1);
    chk({tag, "_bytes"}, fbytes_s, 8);
    chk({tag, "_q_empty"}, q_s.size(), 0);
    chk({tag, "_rd_cnt"}, raddr_s, NS);
    chk({tag, "_busy_low"}, busy_s, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int rel;
    logic [7:0] csum_f;
    mem_s[0] = 17'h10203;
    mem_s[1] = 17'h000A5;
    for (int i = 0; i < NF; i++) mem_f[i] = DW'(i);

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", rd_en_s, 0);
    chk("rst_rd_addr", rd_addr_s, 0);
    chk("rst_tx_data", tx_data_s, 0);
    chk("rst_tx_start", tx_start_s, 0);
    chk("rst_busy", busy_s, 0);
    chk("rst_done", done_s, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Reset while SEND has tx_start pending; the frame must simply vanish.
    hold_s = 1'b1;
    pulse(1'b0);
    repeat (20) @(posedge clk);
    #1 hold_s = 1'b0;
    #1 chk("t1_start_pending", tx_start_s, 1);
    reset = 1'b1;
    #1;
    chk("t1_rst_tx_start", tx_start_s, 0);
    chk("t1_rst_busy", busy_s, 0);
    chk("t1_rst_rd_en", rd_en_s, 0);
    chk("t1_rst_tx_data", tx_data_s, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("t1_idle_busy", busy_s, 0);
    chk("t1_no_bytes", nbytes_s, 0);

    // Fresh two-word frame at read latency 2.
    push_frame_s();
    d0 = ndone_s;
    pulse(1'b0);
    wait_done(1'b0, 2000, 1'b0, "t2_done_seen");
    frame_checks_s(d0, "t2");

    // Back-pressure before the header.
    hold_s = 1'b1;
    push_frame_s();
    d0 = ndone_s;
    pulse(1'b0);
    repeat (500) @(posedge clk);
    #1 chk("t4_no_bytes_held", fbytes_s, 0);
    rel = cyc;
    hold_s = 1'b0;
    wait_done(1'b0, 2000, 1'b0, "t4_done_seen");
    chk("t4_hdr_cycle", hdr_cyc_s, rel);
    frame_checks_s(d0, "t4");

    // Start mid-frame and again during FIN; both must be ignored.
    push_frame_s();
    d0 = ndone_s;
    pulse(1'b0);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (fbytes_s >= 3) break;
    end
    chk("t5_reached_byte3", {31'h0, fbytes_s >= 3}, 1);
    pulse(1'b0);
    wait_done(1'b0, 2000, 1'b1, "t5_done_seen");
    frame_checks_s(d0, "t5");

    // Full 192-word frame.
    push_frame_f(csum_f);
    d0 = ndone_f;
    pulse(1'b1);
    wait_done(1'b1, 20000, 1'b0, "t6_done_seen");
    repeat (40) @(posedge clk);
    #1;
    chk("t6_done_cnt", ndone_f - d0, 1);
    chk("t6_bytes", fbytes_f, 2 + NF * 3);
    chk("t6_q_empty", q_f.size(), 0);
    chk("t6_rd_cnt", raddr_f, NF);
    chk("t6_last_addr", rd_addr_f, NF - 1);
    chk("t6_tail", last4_f[31:8], 24'h0000BF);
    chk("t6_csum", last4_f[7:0], csum_f);
    chk("t6_busy_low", busy_f, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_uart_sender.md
Name: result_uart_sender

Overview:
- Streams the convolution result memory back to the host over the existing UART transmitter; it is the transmit-side counterpart of the receive-and-store input loader.
- Reads NUM_WORDS signed results from the result BRAM through its read port (addrb/doutb).
- Sends each result as big-endian, sign-extended bytes, framed by a header byte and a trailing XOR checksum.
- Drives the tx_start/tx_data/tx_busy interface of uart_basic.

Parameters:
- DATA_WIDTH, 17, width of one signed result word read from BRAM.
- BYTES_PER_WORD, 3, bytes sent per word; must satisfy 8*BYTES_PER_WORD >= DATA_WIDTH.
- NUM_WORDS, 192, words per frame (3 filters x 64 addresses); read addresses run 0..NUM_WORDS-1.
- ADDR_WIDTH, 8, BRAM read address width.
- READ_LATENCY, 1, clk cycles from rd_addr/rd_en to valid rd_data (1..3).
- HEADER_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle request to send a frame; sampled only in IDLE.
- rd_en, output, 1, BRAM read enable (enb).
- rd_addr, output, ADDR_WIDTH, BRAM read address (addrb).
- rd_data, input, DATA_WIDTH, BRAM read data (doutb).
- tx_data, output, 8, byte to UART.
- tx_start, output, 1, one-cycle send pulse to UART.
- tx_busy, input, 1, UART transmitter busy.
- busy, output, 1, high from accepted start until done.
- done, output, 1, one-cycle pulse when the frame is fully shifted out.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; rd_en=0, rd_addr=0, tx_data=0, tx_start=0, busy=0, done=0; word counter, byte index and checksum cleared.
- Reset mid-frame: the frame is abandoned. No further tx_start is issued. A byte already inside the UART finishes on its own.
- States and transitions:
  - IDLE: on start, go to HDR; busy=1; checksum=0; word_cnt=0.
  - HDR: tx_data=HEADER_BYTE; go to SEND.
  - FETCH: rd_en=1 for one cycle with rd_addr=word_cnt; go to RDWAIT.
  - RDWAIT: count READ_LATENCY cycles after the rd_en cycle. Then latch rd_data into shift register sreg, sign-extended to 8*BYTES_PER_WORD bits, set byte_idx=0, go to LOAD.
  - LOAD: tx_data=sreg[top byte]; checksum ^= that byte; go to SEND.
  - SEND: wait until tx_busy=0. Then tx_start=1 for exactly one cycle, with tx_data stable that cycle and held until the next load. Go to ACKH.
  - ACKH: wait for tx_busy=1. If tx_busy is still 0 after 4 cycles, treat the byte as accepted and go to ACKL (guards against a UART that is immediately idle).
  - ACKL: wait for tx_busy=0, then go to NEXT.
  - NEXT: choose the next byte to send.
    - Just sent the header: go to FETCH.
    - Just sent the checksum: go to FIN.
    - byte_idx < BYTES_PER_WORD-1: shift sreg left 8, byte_idx++, go to LOAD.
    - Else if word_cnt == NUM_WORDS-1: tx_data=checksum, go to SEND with a checksum flag set.
    - Else: word_cnt++, go to FETCH.
  - FIN: done=1 for one cycle; busy=0; go to IDLE.
- The checksum is the XOR of all data bytes and excludes the header.
- Frame length is 2 + NUM_WORDS*BYTES_PER_WORD bytes.
- tx_start is never asserted while tx_busy=1. tx_start is never asserted on two consecutive cycles.
- start while busy=1 is ignored and not queued. start in the same cycle as FIN is ignored; a new frame needs start in IDLE.
- rd_addr holds its last value when rd_en=0. rd_en is asserted exactly NUM_WORDS times per frame.
- word_cnt never wraps: the last address read is NUM_WORDS-1. NUM_WORDS=1 is legal.

Test Plan:
1. Reset behaviour: assert reset mid-SEND with tx_start pending -> tx_start, busy, rd_en go 0 immediately. After release, IDLE; start then produces a fresh frame beginning with A5.
2. Two-word frame: NUM_WORDS=2, BRAM[0]=17'h10203, BRAM[1]=17'h000A5, UART model raises tx_busy 1 cycle after tx_start for 10 cycles.
   - Required bytes: A5, FF, 02, 03, 00, 00, A5, 5B.
   - Then done pulses once and busy falls.
3. Read latency: READ_LATENCY=2, BRAM model returns data 2 cycles late -> identical byte stream to test 2. rd_en pulses exactly 2 times, at addresses 0 then 1.
4. Back-pressure: hold tx_busy=1 for 500 cycles before the first byte -> no tx_start while busy. Header is sent on the first cycle after tx_busy=0 is seen.
5. Start while busy: pulse start at byte 3 of frame -> stream unchanged, exactly one done.
6. Full frame: NUM_WORDS=192, BRAM[i]=i -> 578 bytes. The last 3 data bytes are 00 00 BF, and the checksum equals the bench-computed XOR.
